// File: rtl/tile_select_ctrl.sv
// Tile selection controller: accepts a requested tile index, swaps it in on
// a frame boundary and blinks the display blank for a few frames afterwards.
module tile_select_ctrl #(
    parameter int FLASH_FRAMES = 6,
    parameter int BLINK_FRAMES = 2,
    parameter int MAX_TILE     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic [2:0] score_in,
    input  logic       score_valid,
    output logic       score_ready,
    output logic [2:0] tile_sel,
    output logic       blank,
    output logic       busy
);

    localparam int KW = $clog2(FLASH_FRAMES + 1);
    localparam logic [KW-1:0] FLASH_K = KW'(FLASH_FRAMES);
    localparam logic [KW-1:0] BLINK_K = KW'(BLINK_FRAMES);
    localparam logic [2:0]    MAX_T   = 3'(MAX_TILE);

    typedef enum logic [1:0] {
        S_SHOW,
        S_ARMED,
        S_FLASH
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_vsync_d;
    logic          w_tick;

    logic          r_pend_v;
    logic [2:0]    r_pend_val;
    logic          w_xfer;
    logic          w_pend_clr;
    logic          w_pend_v_nxt;
    logic [2:0]    w_clamp;

    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_nxt;
    logic [KW-1:0] w_k_inc;
    logic          w_k_odd;

    logic [2:0]    r_tile;
    logic [2:0]    w_tile_nxt;
    logic          r_blank;
    logic          w_blank_nxt;
    logic          r_busy;
    logic          w_busy_nxt;

    // Frame tick is the falling edge of the active-low vsync.
    assign w_tick = r_vsync_d & ~vsync;

    // A request can only be taken while the single pending slot is empty.
    assign w_xfer  = score_valid & ~r_pend_v;
    assign w_clamp = (score_in > MAX_T) ? MAX_T : score_in;

    // Frame index of the tick being processed and its blink phase parity.
    assign w_k_inc = r_k + KW'(1);
    assign w_k_odd = ((w_k_inc / BLINK_K) & KW'(1)) != '0;

    assign score_ready = ~r_pend_v;
    assign tile_sel    = r_tile;
    assign blank       = r_blank;
    assign busy        = r_busy;

    // Remember the previous vsync level for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b1;
        end else begin
            r_vsync_d <= vsync;
        end
    end

    // Pending request slot: filled on a transfer, emptied when consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_v   <= 1'b0;
            r_pend_val <= 3'd0;
        end else begin
            r_pend_v <= w_pend_v_nxt;
            if (w_xfer) begin
                r_pend_val <= w_clamp;
            end
        end
    end

    // State, frame counter and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_SHOW;
            r_k     <= '0;
            r_tile  <= 3'd0;
            r_blank <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_tile  <= w_tile_nxt;
            r_blank <= w_blank_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state logic: display changes happen only on frame ticks.
    always_comb begin
        w_state_nxt = r_state;
        w_tile_nxt  = r_tile;
        w_blank_nxt = r_blank;
        w_k_nxt     = r_k;
        w_pend_clr  = 1'b0;
        unique case (r_state)
            S_SHOW: begin
                w_blank_nxt = 1'b0;
                if (r_pend_v) begin
                    if (r_pend_val == r_tile) begin
                        w_pend_clr = 1'b1;
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (w_tick) begin
                    w_tile_nxt  = r_pend_val;
                    w_pend_clr  = 1'b1;
                    w_k_nxt     = '0;
                    w_blank_nxt = 1'b0;
                    w_state_nxt = S_FLASH;
                end
            end
            S_FLASH: begin
                if (w_tick) begin
                    if (w_k_inc >= FLASH_K) begin
                        w_k_nxt     = '0;
                        w_blank_nxt = 1'b0;
                        w_state_nxt = S_SHOW;
                    end else begin
                        w_k_nxt     = w_k_inc;
                        w_blank_nxt = w_k_odd;
                    end
                end
            end
            default: begin
                w_state_nxt = S_SHOW;
                w_k_nxt     = '0;
                w_blank_nxt = 1'b0;
            end
        endcase
        w_pend_v_nxt = w_xfer | (r_pend_v & ~w_pend_clr);
        w_busy_nxt   = (w_state_nxt != S_SHOW) | w_pend_v_nxt;
    end

endmodule

// File: tb/tb_tile_select_ctrl.sv
// Bench for tile_select_ctrl: frame-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_tile_select_ctrl;

    localparam int FF = 6;
    localparam int BF = 2;
    localparam int MT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic [2:0] score_in = 3'd0;
    logic       score_valid = 1'b0;
    logic       score_ready;
    logic [2:0] tile_sel;
    logic       blank;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    tile_select_ctrl #(
        .FLASH_FRAMES(FF),
        .BLINK_FRAMES(BF),
        .MAX_TILE(MT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vsync(vsync),
        .score_in(score_in),
        .score_valid(score_valid),
        .score_ready(score_ready),
        .tile_sel(tile_sel),
        .blank(blank),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: request queue, shown tile, frames since the swap.
    bit m_known = 0;
    int m_tile = 0;
    int m_blank = 0;
    int pq[$];
    bit m_armed = 0;
    bit m_fl = 0;
    int m_n = 0;
    bit m_vd = 1;

    initial forever begin
        bit tk;
        bit acc;
        @(posedge clk);
        if (!rst_n) begin
            m_known = 1;
            m_tile = 0;
            m_blank = 0;
            pq.delete();
            m_armed = 0;
            m_fl = 0;
            m_n = 0;
            m_vd = 1;
        end else begin
            tk = m_vd && !vsync;
            m_vd = vsync;
            acc = score_valid && (pq.size() == 0);
            if (m_fl) begin
                if (tk) begin
                    m_n++;
                    if (m_n >= FF) begin
                        m_fl = 0;
                        m_blank = 0;
                    end else begin
                        m_blank = ((m_n / BF) % 2 == 1) ? 1 : 0;
                    end
                end
            end else if (m_armed) begin
                if (tk) begin
                    m_tile = pq.pop_front();
                    m_armed = 0;
                    m_fl = 1;
                    m_n = 0;
                    m_blank = 0;
                end
            end else if (pq.size() != 0) begin
                if (pq[0] == m_tile) void'(pq.pop_front());
                else m_armed = 1;
            end
            if (acc) pq.push_back((int'(score_in) > MT) ? MT : int'(score_in));
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (m_known) begin
            chk("m_tile", 32'(tile_sel), 32'(m_tile));
            chk("m_blank", 32'(blank), 32'(m_blank));
            chk("m_busy", 32'(busy), 32'(m_armed || m_fl || pq.size() != 0));
            chk("m_ready", 32'(score_ready), 32'(pq.size() == 0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
    endtask

    task automatic send(input logic [2:0] v);
        @(negedge clk);
        score_valid = 1'b1;
        score_in = v;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic finish_flash();
        for (int k = 1; k <= FF; k++) begin
            cyc(2);
            tick();
        end
    endtask

    int bexp[6] = '{0, 1, 1, 0, 0, 0};

    initial begin
        // Reset for two cycles.
        cyc(2);
        rst_n = 1'b1;
        chk("rst_tile", 32'(tile_sel), 0);
        chk("rst_blank", 32'(blank), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(score_ready), 1);

        // Basic change to tile 3 with blink pattern.
        cyc(3);
        send(3'd3);
        chk("basic_ready0", 32'(score_ready), 0);
        tick();
        chk("basic_tile", 32'(tile_sel), 3);
        chk("basic_blank0", 32'(blank), 0);
        for (int k = 1; k <= FF; k++) begin
            cyc(2);
            tick();
            chk($sformatf("basic_blank_k%0d", k), 32'(blank), 32'(bexp[k-1]));
        end
        chk("basic_busy_end", 32'(busy), 0);

        // Same value: no flash, busy for a single cycle.
        cyc(2);
        send(3'd3);
        chk("same_busy1", 32'(busy), 1);
        cyc(1);
        chk("same_busy0", 32'(busy), 0);
        chk("same_ready", 32'(score_ready), 1);
        chk("same_blank", 32'(blank), 0);
        chk("same_tile", 32'(tile_sel), 3);

        // Clamp 7 -> 5, with a request queued during the flash.
        cyc(2);
        send(3'd7);
        tick();
        chk("clamp_tile", 32'(tile_sel), 5);
        cyc(2);
        tick();
        send(3'd2);
        chk("queue_ready0", 32'(score_ready), 0);
        @(negedge clk);
        score_valid = 1'b1;
        score_in = 3'd4;
        cyc(3);
        score_valid = 1'b0;
        for (int k = 2; k <= FF; k++) begin
            cyc(2);
            tick();
        end
        chk("queue_tile_hold", 32'(tile_sel), 5);
        chk("queue_ready_end", 32'(score_ready), 0);
        chk("queue_busy_end", 32'(busy), 1);
        cyc(2);
        tick();
        chk("queue_tile", 32'(tile_sel), 2);
        finish_flash();
        chk("queue_busy_done", 32'(busy), 0);

        // Transfer coincident with a tick: waits for the next tick.
        cyc(2);
        @(negedge clk);
        score_valid = 1'b1;
        score_in = 3'd1;
        vsync = 1'b0;
        @(negedge clk);
        score_valid = 1'b0;
        vsync = 1'b1;
        chk("coin_tile0", 32'(tile_sel), 2);
        chk("coin_busy", 32'(busy), 1);
        cyc(3);
        chk("coin_tile1", 32'(tile_sel), 2);
        tick();
        chk("coin_tile2", 32'(tile_sel), 1);
        finish_flash();

        // Reset mid-flash with a queued request and valid held high.
        cyc(2);
        send(3'd4);
        tick();
        chk("rmid_tile", 32'(tile_sel), 4);
        cyc(2);
        tick();
        send(3'd0);
        cyc(1);
        tick();
        cyc(2);
        tick();
        chk("rmid_blank_k3", 32'(blank), 1);
        @(negedge clk);
        rst_n = 1'b0;
        score_valid = 1'b1;
        score_in = 3'd5;
        @(negedge clk);
        rst_n = 1'b1;
        score_valid = 1'b0;
        chk("rmid_tile0", 32'(tile_sel), 0);
        chk("rmid_blank0", 32'(blank), 0);
        chk("rmid_busy0", 32'(busy), 0);
        chk("rmid_ready1", 32'(score_ready), 1);
        cyc(3);
        tick();
        chk("rmid_discard", 32'(tile_sel), 0);
        chk("rmid_idle", 32'(busy), 0);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
